// File: rtl/rf_ctrl_pkg.sv
// Shared register-file control types: write-back arbitration states and
// the write-port payload record.
package rf_ctrl_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int X0_ADDR   = 0;

  typedef enum logic {
    PRIO_LSU = 1'b0,
    PRIO_ALU = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/wb_wait_counter.sv
// Saturating count of consecutive cycles the ALU lost write-port arbitration.
// sat_o looks one edge ahead so the priority flip lands with the last loss.
module wb_wait_counter #(
  parameter  int MAX_WAIT = 3,
  localparam int CNT_W    = $clog2(MAX_WAIT + 1)
) (
  input  logic clk,
  input  logic RST,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_W'(MAX_WAIT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign sat_o = (cnt_d == CNT_W'(MAX_WAIT));

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between the ALU result path
// and the LSU load-return path; x0 writes are absorbed without a grant.
module regfile_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd_addr,
  input  logic [DATA_W-1:0] alu_rd_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_rd_addr,
  input  logic [DATA_W-1:0] lsu_rd_data,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_wren,
  output logic              o_last_lsu
);

  wb_state_t         state_q, state_d;
  logic              alu_x0, lsu_x0;
  logic              alu_req, lsu_req;
  logic              grant_alu, grant_lsu;
  logic              alu_sat;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_wren_q;
  logic              last_lsu_q;

  assign alu_x0  = (alu_rd_addr == ADDR_W'(X0_ADDR));
  assign lsu_x0  = (lsu_rd_addr == ADDR_W'(X0_ADDR));
  assign alu_req = alu_valid && !alu_x0;
  assign lsu_req = lsu_valid && !lsu_x0;

  // Only non-x0 requests compete; the state decides a conflict.
  assign grant_alu = !RST && alu_req && (!lsu_req || (state_q == PRIO_ALU));
  assign grant_lsu = !RST && lsu_req && (!alu_req || (state_q == PRIO_LSU));

  assign alu_ready = !RST && (alu_x0 || grant_alu);
  assign lsu_ready = !RST && (lsu_x0 || grant_lsu);

  wb_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_cnt (
    .clk   (clk),
    .RST   (RST),
    .inc_i (alu_req && !grant_alu),
    .clr_i (alu_valid && alu_ready),
    .sat_o (alu_sat)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      PRIO_LSU: if (alu_sat)   state_d = PRIO_ALU;
      PRIO_ALU: if (grant_alu) state_d = PRIO_LSU;
      default:                 state_d = PRIO_LSU;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q <= PRIO_LSU;
    end else begin
      state_q <= state_d;
    end
  end

  // Write-port register: one-cycle write enable, payload holds between writes.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      rd_wren_q  <= 1'b0;
      last_lsu_q <= 1'b0;
    end else begin
      rd_wren_q <= grant_alu || grant_lsu;
      if (grant_lsu) begin
        rd_addr_q  <= lsu_rd_addr;
        rd_data_q  <= lsu_rd_data;
        last_lsu_q <= 1'b1;
      end else if (grant_alu) begin
        rd_addr_q  <= alu_rd_addr;
        rd_data_q  <= alu_rd_data;
        last_lsu_q <= 1'b0;
      end
    end
  end

  assign o_rd_addr  = rd_addr_q;
  assign o_rd_data  = rd_data_q;
  assign o_rd_wren  = rd_wren_q;
  assign o_last_lsu = last_lsu_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: single-cycle vector table, multi-cycle
// corner sequences, and randomized traffic against a grant-order model.
module tb_regfile_wb_arbiter;
  import rf_ctrl_pkg::*;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int MAX_WAIT = 3;

  logic              clk = 1'b0;
  logic              RST = 1'b1;
  logic              alu_valid = 1'b0, lsu_valid = 1'b0;
  logic              alu_ready, lsu_ready;
  logic [ADDR_W-1:0] alu_rd_addr = '0, lsu_rd_addr = '0;
  logic [DATA_W-1:0] alu_rd_data = '0, lsu_rd_data = '0;
  logic [ADDR_W-1:0] o_rd_addr;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_rd_wren, o_last_lsu;

  int n_pass = 0;
  int n_total = 0;

  regfile_wb_arbiter #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk         (clk),
    .RST         (RST),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd_addr (alu_rd_addr),
    .alu_rd_data (alu_rd_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd_addr (lsu_rd_addr),
    .lsu_rd_data (lsu_rd_data),
    .o_rd_addr   (o_rd_addr),
    .o_rd_data   (o_rd_data),
    .o_rd_wren   (o_rd_wren),
    .o_last_lsu  (o_last_lsu)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              av;
    logic [ADDR_W-1:0] aa;
    logic [DATA_W-1:0] ad;
    logic              lv;
    logic [ADDR_W-1:0] la;
    logic [DATA_W-1:0] ld;
    logic              e_ar;
    logic              e_lr;
    logic              e_wren;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    logic              e_last;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    alu_rd_addr = 5'd1; lsu_rd_addr = 5'd2;
    alu_rd_data = '0; lsu_rd_data = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    RST = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    RST = 1'b0;
  endtask

  task automatic drive_alu(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    alu_valid = v; alu_rd_addr = a; alu_rd_data = d;
  endtask

  task automatic drive_lsu(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    lsu_valid = v; lsu_rd_addr = a; lsu_rd_data = d;
  endtask

  // Reference model state for random traffic
  int     losses;
  rf_wr_t m_wr;
  logic   m_wren, m_last;
  logic   alu_done, lsu_done;

  initial begin
    vecs[0] = '{1, 5'd7, 32'h1234_5678, 0, 5'd2, 32'h0,    1, 0, 1, 5'd7, 32'h1234_5678, 0};
    vecs[1] = '{0, 5'd1, 32'h0,         1, 5'd9, 32'hCAFE, 0, 1, 1, 5'd9, 32'hCAFE,      1};
    vecs[2] = '{1, 5'd3, 32'h33,        1, 5'd4, 32'h44,   0, 1, 1, 5'd4, 32'h44,        1};
    vecs[3] = '{1, 5'd0, 32'hDEAD,      1, 5'd9, 32'h99,   1, 1, 1, 5'd9, 32'h99,        1};
    vecs[4] = '{1, 5'd5, 32'h55,        1, 5'd0, 32'hBEEF, 1, 1, 1, 5'd5, 32'h55,        0};
    vecs[5] = '{1, 5'd0, 32'h11,        1, 5'd0, 32'h22,   1, 1, 0, 5'd0, 32'h0,         0};
    vecs[6] = '{0, 5'd3, 32'h11,        0, 5'd4, 32'h22,   0, 0, 0, 5'd0, 32'h0,         0};

    // Reset state
    idle_inputs();
    #2;
    chk("rst_wren", o_rd_wren, 0);
    chk("rst_addr", o_rd_addr, 0);
    chk("rst_data", o_rd_data, 0);
    chk("rst_last", o_last_lsu, 0);

    for (int i = 0; i < 7; i++) begin
      apply_reset();
      drive_alu(vecs[i].av, vecs[i].aa, vecs[i].ad);
      drive_lsu(vecs[i].lv, vecs[i].la, vecs[i].ld);
      #1;
      chk($sformatf("vec%0d_alu_ready", i), alu_ready, vecs[i].e_ar);
      chk($sformatf("vec%0d_lsu_ready", i), lsu_ready, vecs[i].e_lr);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_wren", i), o_rd_wren, vecs[i].e_wren);
      chk($sformatf("vec%0d_addr", i), o_rd_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d_data", i), o_rd_data, vecs[i].e_data);
      chk($sformatf("vec%0d_last", i), o_last_lsu, vecs[i].e_last);
      @(negedge clk);
      idle_inputs();
      #1;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_wren_drop", i), o_rd_wren, 0);
    end

    // Conflict r3/r4: LSU first, then ALU alone
    apply_reset();
    drive_alu(1, 5'd3, 32'h33);
    drive_lsu(1, 5'd4, 32'h44);
    @(posedge clk); #1;
    chk("ord_first_addr", o_rd_addr, 5'd4);
    @(negedge clk);
    drive_lsu(0, 5'd4, 32'h44);
    #1;
    chk("ord_alu_ready", alu_ready, 1);
    @(posedge clk); #1;
    chk("ord_second_wren", o_rd_wren, 1);
    chk("ord_second_addr", o_rd_addr, 5'd3);
    chk("ord_second_last", o_last_lsu, 0);

    // Starvation guard with continuous LSU traffic
    apply_reset();
    drive_alu(1, 5'd5, 32'h55);
    for (int k = 0; k < 4; k++) begin
      drive_lsu(1, 5'(10 + k), 32'(k));
      #1;
      chk($sformatf("starve%0d_alu_ready", k), alu_ready, (k == 3));
      chk($sformatf("starve%0d_lsu_ready", k), lsu_ready, (k != 3));
      @(posedge clk); #1;
      chk($sformatf("starve%0d_last", k), o_last_lsu, (k != 3));
      @(negedge clk);
    end
    drive_alu(1, 5'd12, 32'h77);
    drive_lsu(1, 5'd20, 32'h20);
    #1;
    chk("starve_back_lsu_ready", lsu_ready, 1);
    chk("starve_back_alu_ready", alu_ready, 0);
    @(negedge clk);

    // Same destination: LSU value lands first, ALU value last
    apply_reset();
    drive_alu(1, 5'd6, 32'hA);
    drive_lsu(1, 5'd6, 32'hB);
    @(posedge clk); #1;
    chk("same_first_data", o_rd_data, 32'hB);
    @(negedge clk);
    drive_lsu(0, 5'd6, 32'hB);
    @(posedge clk); #1;
    chk("same_second_data", o_rd_data, 32'hA);
    chk("same_second_addr", o_rd_addr, 5'd6);
    chk("same_second_last", o_last_lsu, 0);

    // Async reset while writing, after the ALU has earned priority
    apply_reset();
    drive_alu(1, 5'd5, 32'h55);
    drive_lsu(1, 5'd8, 32'h88);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_pre_wren", o_rd_wren, 1);
    #1 RST = 1'b1;
    #1;
    chk("mid_wren", o_rd_wren, 0);
    chk("mid_addr", o_rd_addr, 0);
    chk("mid_data", o_rd_data, 0);
    chk("mid_last", o_last_lsu, 0);
    chk("mid_alu_ready", alu_ready, 0);
    chk("mid_lsu_ready", lsu_ready, 0);
    @(negedge clk);
    RST = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("post_rst%0d_alu_ready", k), alu_ready, (k == 3));
      @(posedge clk); #1;
      chk($sformatf("post_rst%0d_last", k), o_last_lsu, (k != 3));
      @(negedge clk);
    end

    // Randomized traffic against the model
    apply_reset();
    losses = 0;
    m_wr = '0; m_wren = 0; m_last = 0;
    alu_done = 1; lsu_done = 1;
    for (int c = 0; c < 3000; c++) begin
      logic a_nz, l_nz, boost, ga, gl, e_ar, e_lr;
      if (alu_done) begin
        alu_valid   = ($urandom_range(0, 99) < 60);
        alu_rd_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        alu_rd_data = $urandom;
      end
      if (lsu_done) begin
        lsu_valid   = ($urandom_range(0, 99) < 60);
        lsu_rd_addr = ($urandom_range(0, 7) == 0) ? 5'd0 :
                      ($urandom_range(0, 3) == 0) ? alu_rd_addr : 5'($urandom_range(1, 31));
        lsu_rd_data = $urandom;
      end
      #1;
      a_nz  = alu_valid && (alu_rd_addr != 0);
      l_nz  = lsu_valid && (lsu_rd_addr != 0);
      boost = (losses >= MAX_WAIT);
      ga    = a_nz && (!l_nz || boost);
      gl    = l_nz && !ga;
      e_ar  = (alu_rd_addr == 0) || ga;
      e_lr  = (lsu_rd_addr == 0) || gl;
      chk("rnd_alu_ready", alu_ready, e_ar);
      chk("rnd_lsu_ready", lsu_ready, e_lr);
      alu_done = alu_valid ? e_ar : 1'b1;
      lsu_done = lsu_valid ? e_lr : 1'b1;
      if (alu_valid && e_ar) losses = 0;
      else if (a_nz) losses = (losses + 1 > MAX_WAIT) ? MAX_WAIT : losses + 1;
      m_wren = ga || gl;
      if (gl) begin
        m_wr.addr = lsu_rd_addr; m_wr.data = lsu_rd_data; m_last = 1;
      end else if (ga) begin
        m_wr.addr = alu_rd_addr; m_wr.data = alu_rd_data; m_last = 0;
      end
      @(posedge clk); #1;
      chk("rnd_wren", o_rd_wren, m_wren);
      chk("rnd_addr", o_rd_addr, m_wr.addr);
      chk("rnd_data", o_rd_data, m_wr.data);
      chk("rnd_last", o_last_lsu, m_last);
      @(negedge clk);
    end

    idle_inputs();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
